// File: rtl/divider_pkg.sv
// Shared constants and state encoding for the iterative DIV/DIVU unit.
package divider_pkg;

   localparam int DIV_WIDTH      = 32;
   localparam int DIV_ITERATIONS = DIV_WIDTH;   // one quotient bit per clock

   localparam logic [DIV_WIDTH-1:0] DIV_BY_ZERO_QUOTIENT = 32'hFFFFFFFF;

   typedef enum logic [1:0] {
      DIV_IDLE    = 2'd0,
      DIV_BY_ZERO = 2'd1,
      DIV_RUN     = 2'd2,
      DIV_DONE    = 2'd3
   } div_state_t;

endpackage

// File: rtl/divider_step.sv
// One restoring-division iteration: shift in the next dividend bit, try to
// subtract the divisor, keep the difference if it did not go negative.
module divider_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   rem,
   input  logic             next_bit,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   rem_next,
   output logic             q_bit
);

   logic [WIDTH:0]   shifted;
   logic [WIDTH+1:0] diff;
   logic             unused_rem_msb;

   // The partial remainder is always below the divisor, so its top bit is
   // zero on entry and is dropped by the shift.
   assign unused_rem_msb = rem[WIDTH];

   // Trial subtraction; the extra top bit of diff is the borrow.
   always_comb begin
      shifted  = {rem[WIDTH-1:0], next_bit};
      diff     = {1'b0, shifted} - {2'b00, divisor};
      q_bit    = ~diff[WIDTH+1];
      rem_next = q_bit ? diff[WIDTH:0] : shifted;
   end

endmodule

// File: rtl/divider.sv
// Iterative 32-bit signed/unsigned restoring divider for DIV/DIVU.
// result = {remainder, quotient}; execute stalls on stall_request until done.
module divider
   import divider_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic               annul,
   input  logic               signed_div,
   input  logic [WIDTH-1:0]   operand_a,
   input  logic [WIDTH-1:0]   operand_b,
   output logic [2*WIDTH-1:0] result,
   output logic               done,
   output logic               stall_request
);

   localparam int             CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   div_state_t       state;
   logic [CW-1:0]    counter;
   logic [WIDTH-1:0] dvd;      // dividend shifts out MSB-first, quotient shifts in
   logic [WIDTH-1:0] dvs;
   logic [WIDTH:0]   rem;
   logic [WIDTH:0]   rem_next;
   logic             q_bit;
   logic             neg_q;
   logic             neg_r;
   logic [WIDTH-1:0] a_abs;
   logic [WIDTH-1:0] b_abs;
   logic [WIDTH-1:0] q_final;
   logic [WIDTH-1:0] r_final;
   logic             unused_rem_next_msb;

   divider_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem),
      .next_bit (dvd[WIDTH-1]),
      .divisor  (dvs),
      .rem_next (rem_next),
      .q_bit    (q_bit)
   );

   // Operand magnitudes (only for DIV) and the values the last iteration yields.
   always_comb begin
      a_abs   = (signed_div & operand_a[WIDTH-1]) ? -operand_a : operand_a;
      b_abs   = (signed_div & operand_b[WIDTH-1]) ? -operand_b : operand_b;
      q_final = {dvd[WIDTH-2:0], q_bit};
      r_final = rem_next[WIDTH-1:0];
   end

   assign unused_rem_next_msb = rem_next[WIDTH];

   // Execute holds while an op is in flight or is being accepted this cycle.
   assign stall_request = (state == DIV_RUN) | (state == DIV_BY_ZERO) |
                          ((state == DIV_IDLE) & start & ~annul);

   // Control FSM with datapath registers; annul drops any op without touching result.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= DIV_IDLE;
         counter <= '0;
         dvd     <= '0;
         dvs     <= '0;
         rem     <= '0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         result  <= '0;
         done    <= 1'b0;
      end else begin
         case (state)
            DIV_IDLE: begin
               if (start && !annul) begin
                  neg_q   <= signed_div & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
                  neg_r   <= signed_div & operand_a[WIDTH-1];
                  dvs     <= b_abs;
                  rem     <= '0;
                  counter <= '0;
                  if (operand_b == '0) begin
                     // Raw dividend is returned as the remainder on divide-by-zero.
                     dvd   <= operand_a;
                     state <= DIV_BY_ZERO;
                  end else begin
                     dvd   <= a_abs;
                     state <= DIV_RUN;
                  end
               end
            end
            DIV_BY_ZERO: begin
               if (annul) begin
                  state <= DIV_IDLE;
               end else begin
                  result <= {dvd, WIDTH'(DIV_BY_ZERO_QUOTIENT)};
                  done   <= 1'b1;
                  state  <= DIV_DONE;
               end
            end
            DIV_RUN: begin
               if (annul) begin
                  state <= DIV_IDLE;
               end else begin
                  rem     <= rem_next;
                  dvd     <= q_final;
                  counter <= counter + CW'(1);
                  if (counter == LAST) begin
                     // Remainder follows the dividend's sign; MIN/-1 wraps silently.
                     result <= {(neg_r ? -r_final : r_final),
                                (neg_q ? -q_final : q_final)};
                     done   <= 1'b1;
                     state  <= DIV_DONE;
                  end
               end
            end
            DIV_DONE: begin
               if (annul || !start) begin
                  done  <= 1'b0;
                  state <= DIV_IDLE;
               end
            end
            default: state <= DIV_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: transaction-level reference model plus
// directed vectors with hand-computed results.
module tb_divider;

   logic        clock;
   logic        reset;
   logic        start;
   logic        annul;
   logic        signed_div;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic [63:0] result;
   logic        done;
   logic        stall_request;

   int checks   = 0;
   int failures = 0;

   divider dut (
      .clock         (clock),
      .reset         (reset),
      .start         (start),
      .annul         (annul),
      .signed_div    (signed_div),
      .operand_a     (operand_a),
      .operand_b     (operand_b),
      .result        (result),
      .done          (done),
      .stall_request (stall_request)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Architectural result of DIV/DIVU, straight from the arithmetic definition.
   function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
      longint sa, sb, q, r;
      if (b == 32'd0) return {a, 32'hFFFFFFFF};
      if (!s) return {a % b, a / b};
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", name, got, exp);
      end
   endtask

   // Transaction model: an accepted op is busy for a fixed number of edges
   // (32 normally, 1 for a zero divisor), then its result is presented.
   int          m_busy = 0;
   logic        m_done = 1'b0;
   logic [63:0] m_res  = '0;
   logic [63:0] m_pend = '0;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_busy = 0;
         m_done = 1'b0;
         m_res  = '0;
      end else if (m_busy > 0) begin
         if (annul) m_busy = 0;
         else begin
            m_busy--;
            if (m_busy == 0) begin
               m_done = 1'b1;
               m_res  = m_pend;
            end
         end
      end else if (m_done) begin
         if (annul || !start) m_done = 1'b0;
      end else if (start && !annul) begin
         m_pend = ref_div(operand_a, operand_b, signed_div);
         m_busy = (operand_b == 32'd0) ? 1 : 32;
      end
   end

   // Every cycle, mid-period, compare all outputs with the model.
   always @(posedge clock) begin
      #4;
      chk("cyc_done", {63'd0, done}, {63'd0, m_done});
      chk("cyc_result", result, m_res);
      chk("cyc_stall", {63'd0, stall_request},
          {63'd0, (m_busy > 0) || (!m_done && start && !annul)});
   end

   // Issue one op and wait (bounded) for done; returns edges from accept.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output int lat);
      lat = 0;
      operand_a = a; operand_b = b; signed_div = s; start = 1'b1;
      repeat (40) begin
         @(posedge clock); #1;
         lat++;
         if (done) break;
      end
      if (!done) begin
         checks++; failures++;
         $display("FAIL timeout got=%0d cycles expected=done", lat);
      end
   endtask

   task automatic op_check(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic [63:0] exp, input int exp_lat);
      int lat;
      run_op(a, b, s, lat);
      chk({name, "_result"}, result, exp);
      chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
      start = 1'b0;
      operand_a = 32'hDEAD_BEEF; operand_b = 32'h0;
      @(posedge clock); #1;
      chk({name, "_idle"}, {63'd0, done}, 64'd0);
   endtask

   initial begin
      int lat;
      reset = 1'b0; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
      operand_a = '0; operand_b = '0;

      // Pin the model against hand-derived answers.
      chk("model_divu", ref_div(32'd100, 32'd7, 1'b0), 64'h00000002_0000000E);
      chk("model_div", ref_div(32'hFFFFFFF9, 32'd2, 1'b1), 64'hFFFFFFFF_FFFFFFFD);
      chk("model_ovf", ref_div(32'h80000000, 32'hFFFFFFFF, 1'b1), 64'h00000000_80000000);
      chk("model_zero", ref_div(32'h12345678, 32'd0, 1'b1), 64'h12345678_FFFFFFFF);

      repeat (2) @(posedge clock);
      #1;
      chk("reset_done", {63'd0, done}, 64'd0);
      chk("reset_result", result, 64'd0);
      chk("reset_stall", {63'd0, stall_request}, 64'd0);
      reset = 1'b1;
      @(posedge clock); #1;

      op_check("divu_100_7", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 33);
      op_check("div_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 33);
      op_check("divu_m7_2", 32'hFFFFFFF9, 32'd2, 1'b0, 64'h00000001_7FFFFFFC, 33);
      op_check("div_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, 33);
      op_check("div_7_m2", 32'd7, 32'hFFFFFFFE, 1'b1, 64'h00000001_FFFFFFFD, 33);
      op_check("divu_zero", 32'h12345678, 32'd0, 1'b0, 64'h12345678_FFFFFFFF, 2);
      op_check("div_zero", 32'h87654321, 32'd0, 1'b1, 64'h87654321_FFFFFFFF, 2);

      // Annul at counter=10: op vanishes, previous result stays.
      operand_a = 32'd1000; operand_b = 32'd3; signed_div = 1'b0; start = 1'b1;
      repeat (11) @(posedge clock);          // accept edge + 10 iterations
      #1;
      chk("annul_stall_before", {63'd0, stall_request}, 64'd1);
      annul = 1'b1; start = 1'b0;
      @(posedge clock); #1;
      annul = 1'b0;
      chk("annul_done", {63'd0, done}, 64'd0);
      chk("annul_result", result, 64'h87654321_FFFFFFFF);
      chk("annul_stall", {63'd0, stall_request}, 64'd0);
      op_check("divu_9_3", 32'd9, 32'd3, 1'b0, 64'h00000000_00000003, 33);

      // Hold start in DONE: done stays, nothing re-issued.
      run_op(32'd50, 32'd6, 1'b0, lat);
      chk("hold_result0", result, 64'h00000002_00000008);
      repeat (3) begin
         @(posedge clock); #1;
         chk("hold_done", {63'd0, done}, 64'd1);
         chk("hold_result", result, 64'h00000002_00000008);
         chk("hold_stall", {63'd0, stall_request}, 64'd0);
      end
      start = 1'b0;
      @(posedge clock); #1;
      chk("hold_release", {63'd0, done}, 64'd0);

      // Asynchronous reset mid-run.
      operand_a = 32'd12345; operand_b = 32'd11; start = 1'b1;
      repeat (6) @(posedge clock);
      #6;
      start = 1'b0;
      reset = 1'b0;
      #1;
      chk("areset_done", {63'd0, done}, 64'd0);
      chk("areset_stall", {63'd0, stall_request}, 64'd0);
      chk("areset_result", result, 64'd0);
      @(posedge clock); #2;
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      op_check("div_m100_7", 32'hFFFFFF9C, 32'd7, 1'b1, 64'hFFFFFFFE_FFFFFFF2, 33);

      repeat (2) @(posedge clock);
      #6;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
